// File: rtl/reorder_buffer_pkg.sv
// Shared sizing and entry layout for the 16-entry reorder buffer.
package rob_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W     = 4;
  localparam int DATA_W    = 16;
  localparam int WIDTH     = 4;
  localparam int NCDB      = 2;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// Allocation, completion and retirement buses of the reorder buffer; slot 0 sits in the MSBs.
interface reorder_buffer_if;
  import rob_pkg::*;

  logic [WIDTH-1:0]        alloc_valid_flat;
  logic [WIDTH-1:0]        alloc_has_dest_flat;
  logic [WIDTH*TAG_W-1:0]  alloc_dest_flat;
  logic                    alloc_ready;
  logic [WIDTH*TAG_W-1:0]  alloc_tag_flat;
  logic [WIDTH-1:0]        rt_update_enable_flat;
  logic [WIDTH*TAG_W-1:0]  rt_target_reg_flat;
  logic [WIDTH*TAG_W-1:0]  rt_owner_flat;
  logic [NCDB-1:0]         cdb_valid_flat;
  logic [NCDB*TAG_W-1:0]   cdb_tag_flat;
  logic [NCDB*DATA_W-1:0]  cdb_data_flat;
  logic [WIDTH-1:0]        retirement_write_data_enable_flat;
  logic [WIDTH*TAG_W-1:0]  retirement_target_reg_flat;
  logic [WIDTH*DATA_W-1:0] retirement_write_data_flat;
  logic [WIDTH*TAG_W-1:0]  instruction_writer_flat;

  modport master (
    output alloc_valid_flat, alloc_has_dest_flat, alloc_dest_flat,
    output cdb_valid_flat, cdb_tag_flat, cdb_data_flat,
    input  alloc_ready, alloc_tag_flat, rt_update_enable_flat, rt_target_reg_flat, rt_owner_flat,
    input  retirement_write_data_enable_flat, retirement_target_reg_flat,
    input  retirement_write_data_flat, instruction_writer_flat
  );

  modport slave (
    input  alloc_valid_flat, alloc_has_dest_flat, alloc_dest_flat,
    input  cdb_valid_flat, cdb_tag_flat, cdb_data_flat,
    output alloc_ready, alloc_tag_flat, rt_update_enable_flat, rt_target_reg_flat, rt_owner_flat,
    output retirement_write_data_enable_flat, retirement_target_reg_flat,
    output retirement_write_data_flat, instruction_writer_flat
  );
endinterface

// File: rtl/reorder_buffer_retire_select.sv
// Counts consecutive completed entries from head, capped at the slot count and occupancy.
module rob_retire_select
  import rob_pkg::*;
(
  input  logic [TAG_W-1:0]     head,
  input  logic [4:0]           count,
  input  logic [ROB_DEPTH-1:0] done_vec,
  output logic [2:0]           r,
  output logic [WIDTH-1:0]     sel
);
  logic run;

  always_comb begin
    r   = '0;
    sel = '0;
    run = 1'b1;
    for (int j = 0; j < WIDTH; j++) begin
      if (run && (5'(j) < count) && done_vec[head + TAG_W'(j)]) begin
        sel[j] = 1'b1;
        r      = r + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end
endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: 4-wide allocate, 2 completion ports, 4-wide in-order retire.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  reorder_buffer_if.slave  bus,
  output logic [4:0]       rob_count
);
  rob_entry_t           ent [ROB_DEPTH];
  logic [TAG_W-1:0]     head, tail;
  logic [4:0]           count;
  logic                 alloc_ready;
  logic [WIDTH-1:0]     av, ahd;
  logic [TAG_W-1:0]     adst [WIDTH];
  logic [TAG_W-1:0]     atag [WIDTH];
  logic [TAG_W-1:0]     rslot [WIDTH];
  logic [NCDB-1:0]      cv;
  logic [TAG_W-1:0]     ctag [NCDB];
  logic [DATA_W-1:0]    cdata [NCDB];
  logic [2:0]           k, r;
  logic [WIDTH-1:0]     rsel;
  logic [ROB_DEPTH-1:0] done_vec;

  always_comb begin
    alloc_ready              = (count <= 5'd12);
    k                        = '0;
    bus.alloc_tag_flat       = '0;
    bus.rt_update_enable_flat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      av[i]    = bus.alloc_valid_flat[WIDTH-1-i];
      ahd[i]   = bus.alloc_has_dest_flat[WIDTH-1-i];
      adst[i]  = bus.alloc_dest_flat[TAG_W*(WIDTH-1-i) +: TAG_W];
      atag[i]  = tail + TAG_W'(i);
      rslot[i] = head + TAG_W'(i);
      bus.alloc_tag_flat[TAG_W*(WIDTH-1-i) +: TAG_W] = atag[i];
      bus.rt_update_enable_flat[WIDTH-1-i] = av[i] & ahd[i] & alloc_ready;
      if (av[i] && alloc_ready) k = k + 3'd1;
    end
    for (int p = 0; p < NCDB; p++) begin
      cv[p]    = bus.cdb_valid_flat[NCDB-1-p];
      ctag[p]  = bus.cdb_tag_flat[TAG_W*(NCDB-1-p) +: TAG_W];
      cdata[p] = bus.cdb_data_flat[DATA_W*(NCDB-1-p) +: DATA_W];
    end
    for (int e = 0; e < ROB_DEPTH; e++) done_vec[e] = ent[e].valid & ent[e].done;
  end

  assign bus.alloc_ready        = alloc_ready;
  assign bus.rt_target_reg_flat = bus.alloc_dest_flat;
  assign bus.rt_owner_flat      = bus.alloc_tag_flat;
  assign rob_count              = count;

  rob_retire_select u_retire_select (
    .head     (head),
    .count    (count),
    .done_vec (done_vec),
    .r        (r),
    .sel      (rsel)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int e = 0; e < ROB_DEPTH; e++) ent[e] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      bus.retirement_write_data_enable_flat <= '0;
      bus.retirement_target_reg_flat        <= '0;
      bus.retirement_write_data_flat        <= '0;
      bus.instruction_writer_flat           <= '0;
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        if (rsel[j]) begin
          bus.retirement_write_data_enable_flat[WIDTH-1-j]              <= ent[rslot[j]].has_dest;
          bus.retirement_target_reg_flat[TAG_W*(WIDTH-1-j) +: TAG_W]   <= ent[rslot[j]].dest;
          bus.retirement_write_data_flat[DATA_W*(WIDTH-1-j) +: DATA_W] <= ent[rslot[j]].value;
          bus.instruction_writer_flat[TAG_W*(WIDTH-1-j) +: TAG_W]      <= rslot[j];
          ent[rslot[j]].valid <= 1'b0;
          ent[rslot[j]].done  <= 1'b0;
        end else begin
          bus.retirement_write_data_enable_flat[WIDTH-1-j]              <= 1'b0;
          bus.retirement_target_reg_flat[TAG_W*(WIDTH-1-j) +: TAG_W]   <= '0;
          bus.retirement_write_data_flat[DATA_W*(WIDTH-1-j) +: DATA_W] <= '0;
          bus.instruction_writer_flat[TAG_W*(WIDTH-1-j) +: TAG_W]      <= '0;
        end
      end
      // Allocated slots are free pre-edge, so they never collide with retiring entries.
      for (int i = 0; i < WIDTH; i++) begin
        if (av[i] && alloc_ready)
          ent[atag[i]] <= '{valid: 1'b1, done: 1'b0, has_dest: ahd[i], dest: adst[i], value: '0};
      end
      // Highest port applied first so port 0 overrides on a shared tag.
      for (int p = NCDB-1; p >= 0; p--) begin
        if (cv[p] && ent[ctag[p]].valid && !ent[ctag[p]].done) begin
          ent[ctag[p]].done  <= 1'b1;
          ent[ctag[p]].value <= cdata[p];
        end
      end
      head  <= head + TAG_W'(r);
      tail  <= tail + TAG_W'(k);
      count <= count + 5'(k) - 5'(r);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= 5'd16);
      assert (bus.alloc_valid_flat inside {4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111});
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized and directed bench for reorder_buffer against a program-order queue model.
module tb_reorder_buffer;
  logic       clk = 1'b0;
  logic       rst, flush;
  logic [4:0] rob_count;

  reorder_buffer_if bus();

  reorder_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .rob_count (rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic        hd;
    logic [3:0]  dest;
    logic        done;
    logic [15:0] val;
  } me_t;

  me_t         q[$];
  logic [3:0]  m_tail;
  logic [3:0]  exp_en;
  logic [15:0] exp_tgt, exp_wr;
  logic [63:0] exp_data;
  int          checks = 0;
  int          errors = 0;

  logic        c_ready;
  logic [3:0]  c_rten;
  logic [15:0] c_owner;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic rs, input logic fl, input logic [3:0] av, input logic [3:0] hd,
                     input logic [15:0] dst, input logic [1:0] cv, input logic [7:0] ct,
                     input logic [31:0] cd);
    logic        ready;
    int          r;
    logic [15:0] tags;
    logic [3:0]  t;
    rst = rs;
    flush = fl;
    bus.alloc_valid_flat    = av;
    bus.alloc_has_dest_flat = hd;
    bus.alloc_dest_flat     = dst;
    bus.cdb_valid_flat      = cv;
    bus.cdb_tag_flat        = ct;
    bus.cdb_data_flat       = cd;
    #1;
    ready = (q.size() <= 12);
    for (int i = 0; i < 4; i++) tags[4*(3-i) +: 4] = m_tail + 4'(i);
    if (!rs) begin
      chk("alloc_ready", 64'(bus.alloc_ready), 64'(ready));
      chk("alloc_tag", 64'(bus.alloc_tag_flat), 64'(tags));
      chk("rt_owner", 64'(bus.rt_owner_flat), 64'(tags));
      chk("rt_target", 64'(bus.rt_target_reg_flat), 64'(dst));
      chk("rt_enable", 64'(bus.rt_update_enable_flat), 64'(av & hd & {4{ready}}));
    end
    c_ready = bus.alloc_ready;
    c_rten  = bus.rt_update_enable_flat;
    c_owner = bus.rt_owner_flat;
    @(posedge clk);
    exp_en = '0; exp_tgt = '0; exp_wr = '0; exp_data = '0;
    if (rs || fl) begin
      q.delete();
      m_tail = '0;
    end else begin
      r = 0;
      while (r < 4 && r < q.size() && q[r].done) r++;
      for (int j = 0; j < r; j++) begin
        exp_en[3-j]            = q[j].hd;
        exp_tgt[4*(3-j) +: 4]  = q[j].dest;
        exp_data[16*(3-j) +: 16] = q[j].val;
        exp_wr[4*(3-j) +: 4]   = q[j].tag;
      end
      for (int p = 0; p < 2; p++) begin
        if (cv[1-p]) begin
          t = ct[4*(1-p) +: 4];
          for (int e = 0; e < q.size(); e++)
            if (q[e].tag == t && !q[e].done) begin
              q[e].done = 1'b1;
              q[e].val  = cd[16*(1-p) +: 16];
            end
        end
      end
      repeat (r) void'(q.pop_front());
      if (ready)
        for (int i = 0; i < 4; i++)
          if (av[3-i]) begin
            q.push_back('{m_tail, hd[3-i], dst[4*(3-i) +: 4], 1'b0, 16'h0});
            m_tail = m_tail + 4'd1;
          end
    end
    #1;
    chk("rob_count", 64'(rob_count), 64'(q.size()));
    chk("ret_enable", 64'(bus.retirement_write_data_enable_flat), 64'(exp_en));
    chk("ret_target", 64'(bus.retirement_target_reg_flat), 64'(exp_tgt));
    chk("ret_data", bus.retirement_write_data_flat, exp_data);
    chk("ret_writer", 64'(bus.instruction_writer_flat), 64'(exp_wr));
  endtask

  task automatic idle();
    cyc(0, 0, 4'h0, 4'h0, 16'h0, 2'b00, 8'h00, 32'h0);
  endtask

  task automatic alloc(input int n, input logic [3:0] hd, input logic [15:0] dst);
    logic [3:0] f;
    f = 4'hF;
    cyc(0, 0, f << (4 - n), hd, dst, 2'b00, 8'h00, 32'h0);
  endtask

  task automatic cdb2(input logic [1:0] cv, input logic [3:0] t0, input logic [3:0] t1,
                      input logic [15:0] d0, input logic [15:0] d1);
    cyc(0, 0, 4'h0, 4'h0, 16'h0, cv, {t0, t1}, {d0, d1});
  endtask

  task automatic rand_cycle();
    logic [3:0]  f, av;
    logic [1:0]  cv;
    logic [7:0]  ct;
    int          n;
    f  = 4'hF;
    n  = $urandom_range(0, 4);
    av = f << (4 - n);
    for (int p = 0; p < 2; p++) begin
      cv[p] = ($urandom_range(0, 9) < 7);
      if (q.size() > 0 && $urandom_range(0, 9) < 8)
        ct[4*p +: 4] = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct[4*p +: 4] = 4'($urandom_range(0, 15));
    end
    cyc(1'b0, ($urandom_range(0, 99) == 0), av, 4'($urandom), 16'($urandom), cv, ct, $urandom);
  endtask

  initial begin
    m_tail = '0;
    // Reset, then a four-wide allocation
    cyc(1, 0, 4'h0, 4'h0, 16'h0, 2'b00, 8'h00, 32'h0);
    chk("reset_count", 64'(rob_count), 64'd0);
    chk("reset_ret_en", 64'(bus.retirement_write_data_enable_flat), 64'd0);
    alloc(4, 4'hF, 16'h1234);
    chk("t1_owner", 64'(c_owner), 64'h0123);
    chk("t1_count", 64'(rob_count), 64'd4);
    chk("t1_ret_en", 64'(bus.retirement_write_data_enable_flat), 64'd0);

    // Out-of-order completion, in-order retire
    cdb2(2'b10, 4'd2, 4'd0, 16'h0022, 16'h0);
    chk("t2_no_retire", 64'(bus.retirement_write_data_enable_flat), 64'd0);
    cdb2(2'b11, 4'd0, 4'd1, 16'h0100, 16'h0111);
    chk("t2_not_same_edge", 64'(bus.retirement_write_data_enable_flat), 64'd0);
    idle();
    chk("t2_ret_en", 64'(bus.retirement_write_data_enable_flat), 64'hE);
    chk("t2_writer", 64'(bus.instruction_writer_flat), 64'h0120);
    chk("t2_count", 64'(rob_count), 64'd1);

    // Fill to full, then a refused request
    alloc(4, 4'hF, 16'h5678);
    alloc(4, 4'hF, 16'h9ABC);
    alloc(3, 4'hF, 16'hDEF0);
    alloc(4, 4'hF, 16'h1111);
    chk("t3_full", 64'(rob_count), 64'd16);
    alloc(4, 4'hF, 16'h2222);
    chk("t3_ready", 64'(c_ready), 64'd0);
    chk("t3_rt_en", 64'(c_rten), 64'd0);
    chk("t3_count", 64'(rob_count), 64'd16);

    // Wrap-around: advance head and tail to 14
    cyc(1, 0, 4'h0, 4'h0, 16'h0, 2'b00, 8'h00, 32'h0);
    alloc(4, 4'hF, 16'h1234);
    alloc(4, 4'hF, 16'h1234);
    alloc(4, 4'hF, 16'h1234);
    alloc(2, 4'hF, 16'h1234);
    for (int i = 0; i < 7; i++) cdb2(2'b11, 4'(2*i), 4'(2*i+1), 16'(i), 16'(i+100));
    repeat (6) idle();
    chk("t4_empty", 64'(rob_count), 64'd0);
    alloc(4, 4'hF, 16'h5678);
    chk("t4_owner", 64'(c_owner), 64'hEF01);
    cdb2(2'b11, 4'd0, 4'd1, 16'hA000, 16'hA001);
    cdb2(2'b11, 4'd14, 4'd15, 16'hA00E, 16'hA00F);
    idle();
    chk("t4_ret_en", 64'(bus.retirement_write_data_enable_flat), 64'hF);
    chk("t4_writer", 64'(bus.instruction_writer_flat), 64'hEF01);
    chk("t4_data", bus.retirement_write_data_flat, 64'hA00E_A00F_A000_A001);

    // Slot without destination
    alloc(4, 4'b1011, 16'h9ABC);
    cdb2(2'b11, 4'd5, 4'd4, 16'h0005, 16'h0004);
    cdb2(2'b11, 4'd3, 4'd2, 16'h0003, 16'h0002);
    idle();
    chk("t5_ret_en", 64'(bus.retirement_write_data_enable_flat), 64'hB);
    chk("t5_writer", 64'(bus.instruction_writer_flat), 64'h2345);

    // Same tag on both CDB ports: port 0 wins
    cyc(1, 0, 4'h0, 4'h0, 16'h0, 2'b00, 8'h00, 32'h0);
    alloc(4, 4'hF, 16'h1234);
    alloc(2, 4'hF, 16'h5600);
    cdb2(2'b11, 4'd0, 4'd1, 16'h0, 16'h1);
    cdb2(2'b11, 4'd2, 4'd3, 16'h2, 16'h3);
    cdb2(2'b10, 4'd4, 4'd0, 16'h4, 16'h0);
    cdb2(2'b11, 4'd5, 4'd5, 16'hAAAA, 16'h5555);
    idle();
    chk("t6_port0_wins", 64'(bus.retirement_write_data_flat[63:48]), 64'hAAAA);
    chk("t6_writer", 64'(bus.instruction_writer_flat[15:12]), 64'd5);

    // Flush with six entries and concurrent activity
    alloc(4, 4'hF, 16'h1234);
    alloc(2, 4'hF, 16'h5600);
    chk("t6_six", 64'(rob_count), 64'd6);
    cyc(0, 1, 4'hF, 4'hF, 16'h4321, 2'b11, 8'h67, 32'h1234_5678);
    chk("t6_flush_count", 64'(rob_count), 64'd0);
    chk("t6_flush_ret", 64'(bus.retirement_write_data_enable_flat), 64'd0);
    alloc(4, 4'hF, 16'h1234);
    chk("t6_owner", 64'(c_owner), 64'h0123);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) rand_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- 16-entry in-order reorder buffer (ROB) for the 4-wide out-of-order core.
- Allocates up to 4 instructions per cycle from the instruction buffer and drives the register file rename-table write port with the new owner tags.
- Captures results from 2 CDB ports.
- Retires up to 4 completed instructions per cycle in program order, driving the register file retirement write port.

Parameters:
- DEPTH, 16, number of entries. Tag = entry index; only 16 is supported.
- TAG_W, 4, tag and architectural register index width.
- DATA_W, 16, result value width.
- WIDTH, 4, allocation and retirement slots per cycle.
- NCDB, 2, number of completion broadcast ports.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries; same effect as rst on ROB state.
- alloc_valid_flat  in  4  per-slot allocate request; must be contiguous from slot 0.
- alloc_has_dest_flat  in  4  slot writes an architectural register.
- alloc_dest_flat  in  16  destination register per slot.
- alloc_ready  out  1  at least 4 free entries.
- alloc_tag_flat  out  16  tag assigned to each slot (tail+i mod 16).
- rt_update_enable_flat  out  4  alloc_valid & alloc_has_dest & alloc_ready.
- rt_target_reg_flat  out  16  equals alloc_dest_flat.
- rt_owner_flat  out  16  equals alloc_tag_flat.
- cdb_valid_flat  in  2  completion valid per port.
- cdb_tag_flat  in  8  completing tag.
- cdb_data_flat  in  32  result value.
- retirement_write_data_enable_flat  out  4  registered; slot retires and has a destination.
- retirement_target_reg_flat  out  16  registered destination.
- retirement_write_data_flat  out  64  registered value.
- instruction_writer_flat  out  16  registered tag of the retiring entry.
- rob_count  out  5  occupancy, 0..16.

Behaviour:
- Flat bus packing: slot i occupies flat bits [W*(3-i)+W-1 : W*(3-i)], so slot 0 is in the MSBs. The same rule applies to the CDB ports with 2 slots.
- Entry state: valid, done, has_dest, dest[3:0], value[15:0]. Pointers: head[3:0], tail[3:0], count[4:0].
- Reset (rst=1 at an edge):
  - head=tail=count=0; all valid and done bits cleared.
  - All four retirement_* outputs are 0 the next cycle.
  - Reset has priority over flush, alloc, CDB and retire.
- Flush: identical state effect to reset, and the retirement outputs are 0 the next cycle. Any alloc or CDB activity in the flush cycle is dropped.
- Allocation:
  - alloc_ready = (count <= 12), computed combinationally from current state.
  - alloc_tag and the rt_* outputs are combinational in the same cycle.
  - Acceptance is all-or-nothing: if alloc_ready=0, nothing is written and the rt_update enables are 0.
  - On acceptance, k = popcount(alloc_valid). Entries tail..tail+k-1 become valid with done=0. tail += k mod 16.
- Completion:
  - cdb_valid[p] with an entry that is valid and not yet done sets done=1 and stores value.
  - A CDB hit on an invalid entry or an already-done entry is ignored.
  - If both ports carry the same tag, port 0 wins.
  - Data written at edge N becomes eligible for retirement at edge N+1, never the same edge.
- Retirement:
  - At each edge, r = the number of consecutive done entries starting at head (0..4, capped at count).
  - Evaluation uses pre-edge state; it stops at the first entry that is not done.
  - Retirement slot j (j<r) is registered as: enable = has_dest, target = dest, data = value, writer = head+j.
  - Slots j>=r have every field 0.
  - The retired entries are invalidated, head += r, and the outputs are valid the cycle after the edge.
  - An entry with no destination consumes its retirement slot but drives enable=0.
- Occupancy: count_next = count + k - r. Simultaneous alloc and retire is legal. Allocation never reuses an entry freed on the same edge, because alloc_ready uses the pre-edge count.
- Wrap-around: head, tail and tags wrap mod 16. Full (count=16) and empty (count=0) are distinguished by count, not by pointer equality.
- Assertions:
  - alloc_valid is non-contiguous.
  - alloc_valid is asserted while alloc_ready=0 is tolerated (ignored) and not asserted.
  - count exceeds 16.

Decomposition:
- Package rob_pkg holds: ROB_DEPTH, TAG_W, DATA_W, WIDTH, NCDB, and the rob_entry_t struct {valid, done, has_dest, dest, value}.
- One sub-module, rob_retire_select: combinational count of consecutive done entries from head, capped at 4 and at count, producing r and per-slot select.

Test Plan:
1. Reset, then alloc 4 (dests 1,2,3,4, all has_dest) -> tags 0,1,2,3; rt_owner_flat=16'h0123; rob_count=4 next cycle; retirement outputs all 0.
2. CDB tag 2 then tags 0,1 -> after tag 2 alone, no retirement. After 0,1 complete, one cycle later, slots 0,1 retire with writers 0,1 and slot 2 (tag 2) also retires. Enable = 4'b1110, rob_count=1.
3. Fill to 12, then request 4 -> accepted (count=16). Further request -> alloc_ready=0, rt_update_enable=0, count unchanged.
4. Wrap: head=14, tail=14, alloc 4 -> tags 14,15,0,1. Complete all, then 4 retire in one cycle with writers 14,15,0,1 and head=2.
5. Entry with has_dest=0 at slot 1, all done -> retirement enable=4'b1011 and the writer field for slot 1 still equals its tag.
6. Both CDB ports carry tag 5, data 16'hAAAA / 16'h5555 -> retires 16'hAAAA. Flush mid-stream with 6 entries -> count=0, outputs 0 next cycle, next alloc starts at tag 0.
